// File: rtl/fp_issue_ctrl_pkg.sv
// Shared definitions for the FP issue controller: state encoding, FPU op
// codes and the default watchdog limit.
package fp_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } fpState_t;

  localparam logic [1:0] FADD = 2'd0;
  localparam logic [1:0] FSUB = 2'd1;
  localparam logic [1:0] FMUL = 2'd2;
  localparam logic [1:0] FCMP = 2'd3;

  localparam int FP_TIMEOUT_DEF = 32;

endpackage

// File: rtl/fp_watchdog.sv
// Watchdog for the FPU handshake: counts while enabled, cleared on start,
// flags expiry in the cycle the count sits at TIMEOUT-1.
module fp_watchdog #(
  parameter int TIMEOUT   = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_WIDTH-1:0] count;

  // Up-counter; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CNT_WIDTH'(1);
  end

  assign expired = en && (count == CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/fp_issue_ctrl.sv
// Sequences the shared multi-cycle FPU for the EX stage: captures operands,
// issues a start, stalls the pipe while the FPU works and returns the result
// with a one-cycle valid. Handles flush-while-busy and a watchdog timeout.
//
// state | meaning
// IDLE  | no FP op outstanding; accept a new one from EX
// ISSUE | operands latched, waiting for fpu_ready_i to pulse start
// WAIT  | FPU busy, pipe stalled, watchdog running
// RESP  | one-cycle result valid, pipe released
// DRAIN | EX op was flushed; wait out the FPU, discard its result
module fp_issue_ctrl
  import fp_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int REG_WIDTH  = 4,
  parameter int OP_WIDTH   = 2,
  parameter int TIMEOUT    = FP_TIMEOUT_DEF,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  FloatingE_i,
  input  logic [OP_WIDTH-1:0]   fp_opE_i,
  input  logic [DATA_WIDTH-1:0] floating_din_1_i,
  input  logic [DATA_WIDTH-1:0] floating_din_2_i,
  input  logic [REG_WIDTH-1:0]  WriteRegE_i,
  input  logic                  flush_i,
  input  logic                  fpu_ready_i,
  input  logic                  fpu_done_i,
  input  logic [DATA_WIDTH-1:0] fpu_result_i,
  output logic                  fpu_start_o,
  output logic [DATA_WIDTH-1:0] fpu_a_o,
  output logic [DATA_WIDTH-1:0] fpu_b_o,
  output logic [OP_WIDTH-1:0]   fpu_op_o,
  output logic                  stall_o,
  output logic                  fp_valid_o,
  output logic [DATA_WIDTH-1:0] fp_result_o,
  output logic [REG_WIDTH-1:0]  fp_wreg_o,
  output logic                  fp_err_o
);

  fpState_t             state;
  logic [REG_WIDTH-1:0] wregLat;
  logic                 accept;
  logic                 wdEn;
  logic                 wdExpired;

  assign accept      = (state == IDLE) && FloatingE_i && !flush_i;
  assign fpu_start_o = (state == ISSUE) && fpu_ready_i;
  assign wdEn        = (state == WAIT) || (state == DRAIN);

  fp_watchdog #(
    .TIMEOUT  (TIMEOUT),
    .CNT_WIDTH(CNT_WIDTH)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (fpu_start_o),
    .en     (wdEn),
    .expired(wdExpired)
  );

  // Stall is combinational so the EX instruction is held in the cycle it is
  // accepted; in DRAIN only a new FP instruction has to wait.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = accept;
      ISSUE:   stall_o = 1'b1;
      WAIT:    stall_o = 1'b1;
      RESP:    stall_o = 1'b0;
      DRAIN:   stall_o = FloatingE_i;
      default: stall_o = 1'b0;
    endcase
  end

  // Issue FSM with registered operand latches and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fpu_a_o     <= '0;
      fpu_b_o     <= '0;
      fpu_op_o    <= '0;
      wregLat     <= '0;
      fp_valid_o  <= 1'b0;
      fp_result_o <= '0;
      fp_wreg_o   <= '0;
      fp_err_o    <= 1'b0;
    end else begin
      fp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            fpu_a_o  <= floating_din_1_i;
            fpu_b_o  <= floating_din_2_i;
            fpu_op_o <= fp_opE_i;
            wregLat  <= WriteRegE_i;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (fpu_ready_i) state <= WAIT;
        end
        WAIT: begin
          // A flush kills the result even if it lands in the same cycle.
          if (flush_i) begin
            state <= fpu_done_i ? IDLE : DRAIN;
          end else if (fpu_done_i) begin
            fp_result_o <= fpu_result_i;
            fp_wreg_o   <= wregLat;
            fp_valid_o  <= 1'b1;
            state       <= RESP;
          end else if (wdExpired) begin
            fp_err_o    <= 1'b1;
            fp_result_o <= '0;
            fp_wreg_o   <= wregLat;
            fp_valid_o  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (fpu_done_i || wdExpired) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
